word_serializer: RTL and testbench

// - Upstream stage of the serial pattern-detector path: buffers parallel words from a producer
//   and emits them one bit per clock as a continuous serial stream on bit_out.
// - bit_out drives the detector's single-bit `in`, which samples it on every clk edge.
// - Small word FIFO decouples producer bursts from the fixed 1 bit/cycle drain.
// - valid/ready handshake on input; bit_valid qualifies the stream for monitors.

---
 rtl/word_serializer_pkg.sv | 18 +
 rtl/word_serializer_if.sv | 23 ++
 rtl/word_serializer_fifo.sv | 61 ++++++
 rtl/word_serializer.sv | 117 +++++++++++
 tb/tb_word_serializer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and width helpers for the word serializer path.
package word_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Occupancy counter must be able to represent DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Producer-side handshake plus the serial stream outputs of the word serializer.
interface word_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             flush;
    logic             bit_out;
    logic             bit_valid;
    logic             word_done;
    logic             idle;

    modport master (
        output in_valid, in_data, flush,
        input  in_ready, bit_out, bit_valid, word_done, idle
    );

    modport slave (
        input  in_valid, in_data, flush,
        output in_ready, bit_out, bit_valid, word_done, idle
    );
endinterface

// File: rtl/word_serializer_fifo.sv
// Small word FIFO with fall-through read data so a pop can load the shifter on the same edge.
module sync_fifo
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int               PTR_W    = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // Full blocks a write even when a pop frees a slot on the same edge.
    assign do_push = push_i & ~full & ~flush_i;
    assign do_pop  = pop_i & ~empty & ~flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = empty;
    assign count_o = count_q;

endmodule

// File: rtl/word_serializer.sv
// Buffers parallel words and drains them one bit per clock as an unbroken serial stream.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    word_serializer_if.slave  bus
);
    localparam int               CNT_W    = cnt_width(DEPTH);
    localparam int               BIT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bcnt_q, bcnt_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             word_done_q, word_done_d;

    logic             push, pop, fifo_empty, fifo_full, cur_bit;
    logic [WIDTH-1:0] fifo_data, shifted;
    logic [CNT_W-1:0] fifo_count;

    assign fifo_full = (fifo_count == FULL_CNT);
    assign push      = bus.in_valid & ~fifo_full;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.flush),
        .data_i  (bus.in_data),
        .data_o  (fifo_data),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign cur_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcnt_d      = bcnt_q;
        bit_out_d   = IDLE_BIT;
        bit_valid_d = 1'b0;
        word_done_d = 1'b0;
        pop         = 1'b0;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        bcnt_d  = LAST_IDX;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bit_out_d   = cur_bit;
                    bit_valid_d = 1'b1;
                    shift_d     = shifted;
                    bcnt_d      = bcnt_q - 1'b1;
                    // Last bit: chain straight into the next word so no gap bit appears.
                    if (bcnt_q == '0) begin
                        word_done_d = 1'b1;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_data;
                            bcnt_d  = LAST_IDX;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bcnt_q      <= '0;
            bit_out_q   <= IDLE_BIT;
            bit_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcnt_q      <= bcnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            word_done_q <= word_done_d;
        end
    end

    assign bus.in_ready  = ~fifo_full;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.word_done = word_done_q;
    assign bus.idle      = fifo_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: queue-based reference model on instance A plus directed literal checks.
module tb_word_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    word_serializer_if #(.WIDTH(8)) ws_a ();
    word_serializer_if #(.WIDTH(8)) ws_b ();

    word_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(ws_a)
    );
    word_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(ws_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model for instance A (MSB first, idle bit 0, depth 4): word queue + pending bit queue.
    logic [7:0] mq[$];
    bit         sh[$];
    logic       m_bit = 1'b0, m_valid = 1'b0, m_done = 1'b0;

    task automatic load_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) sh.push_back(w[i]);
    endtask

    initial begin
        bit can_push;
        forever begin
            @(posedge clk or posedge reset);
            if (reset || ws_a.flush) begin
                mq.delete();
                sh.delete();
                m_bit = 1'b0; m_valid = 1'b0; m_done = 1'b0;
            end else begin
                can_push = (mq.size() < 4);
                if (sh.size() > 0) begin
                    m_bit   = sh.pop_front();
                    m_valid = 1'b1;
                    m_done  = (sh.size() == 0);
                end else begin
                    m_bit = 1'b0; m_valid = 1'b0; m_done = 1'b0;
                end
                if (sh.size() == 0 && mq.size() > 0) load_word(mq.pop_front());
                if (ws_a.in_valid && can_push) mq.push_back(ws_a.in_data);
            end
        end
    end

    bit cmp_en = 1'b0;
    bit stream[$];
    int done_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !reset) begin
                chk("cyc_bit_out",   ws_a.bit_out,   m_bit);
                chk("cyc_bit_valid", ws_a.bit_valid, m_valid);
                chk("cyc_word_done", ws_a.word_done, m_done);
                chk("cyc_in_ready",  ws_a.in_ready,  (mq.size() != 4));
                chk("cyc_idle",      ws_a.idle,      (mq.size() == 0 && sh.size() == 0));
                if (ws_a.bit_valid) stream.push_back(ws_a.bit_out);
                if (ws_a.word_done) done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  w;
        logic [15:0] pat;
        logic [7:0]  got;
        int acc, first_full, dc0;
        bit will, drained;

        ws_a.in_valid = 1'b0; ws_a.in_data = '0; ws_a.flush = 1'b0;
        ws_b.in_valid = 1'b0; ws_b.in_data = '0; ws_b.flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bit_out",   ws_a.bit_out,   1'b0);
        chk("rst_bit_valid", ws_a.bit_valid, 1'b0);
        chk("rst_word_done", ws_a.word_done, 1'b0);
        chk("rst_idle",      ws_a.idle,      1'b1);
        chk("rst_in_ready",  ws_a.in_ready,  1'b1);
        chk("rst_b_idle_bit", ws_b.bit_out,  1'b1);
        #2 reset = 1'b0;
        cmp_en = 1'b1;

        // Single word, MSB first
        @(negedge clk); ws_a.in_valid = 1'b1; ws_a.in_data = 8'hCC;
        $display("txn: A push 0x%02h", ws_a.in_data);
        @(negedge clk); ws_a.in_valid = 1'b0;
        chk("t1_not_idle", ws_a.idle, 1'b0);
        @(negedge clk);
        chk("t1_load_cycle_valid", ws_a.bit_valid, 1'b0);
        w = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_bit",  ws_a.bit_out,   w[7-i]);
            chk("t1_done", ws_a.word_done, (i == 7));
        end
        @(negedge clk);
        chk("t1_end_valid", ws_a.bit_valid, 1'b0);

        // Back-to-back words
        repeat (2) @(negedge clk);
        #1 done_cnt = 0; stream.delete();
        @(negedge clk); ws_a.in_valid = 1'b1; ws_a.in_data = 8'hA5;
        $display("txn: A push 0xa5");
        @(negedge clk); ws_a.in_data = 8'h3C;
        $display("txn: A push 0x3c");
        @(negedge clk); ws_a.in_valid = 1'b0;
        pat = 16'hA53C;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t2_bit",   ws_a.bit_out,   pat[15-i]);
            chk("t2_valid", ws_a.bit_valid, 1'b1);
        end
        repeat (2) @(negedge clk);
        #1 chk("t2_done_pulses", done_cnt, 2);

        // Full FIFO with in_valid held while draining
        stream.delete();
        @(negedge clk); ws_a.in_valid = 1'b1; ws_a.in_data = 8'h10;
        acc = 0; first_full = -1;
        for (int c = 0; c < 12; c++) begin
            will = ws_a.in_ready;
            @(negedge clk);
            if (will) begin
                $display("txn: A push 0x%02h accepted", ws_a.in_data);
                acc++;
                ws_a.in_data = ws_a.in_data + 8'd1;
            end
            if (!ws_a.in_ready && first_full < 0) first_full = acc;
        end
        ws_a.in_valid = 1'b0;
        chk("t3_accepts_before_full", first_full, 5);
        drained = 1'b0;
        for (int c = 0; c < 200 && !drained; c++) begin
            @(negedge clk);
            if (ws_a.idle) drained = 1'b1;
        end
        chk("t3_drain_done", drained, 1'b1);
        #1 chk("t3_stream_len", stream.size(), acc * 8);
        for (int k = 0; k < acc && (k * 8 + 7) < stream.size(); k++) begin
            got = '0;
            for (int b = 0; b < 8; b++) got = {got[6:0], stream[k*8+b]};
            chk("t3_word_order", got, 8'h10 + k[7:0]);
        end

        // LSB first on instance B (idle bit 1)
        @(negedge clk); ws_b.in_valid = 1'b1; ws_b.in_data = 8'h01;
        $display("txn: B push 0x01");
        @(negedge clk); ws_b.in_valid = 1'b0;
        @(negedge clk);
        chk("t4_load_cycle_valid", ws_b.bit_valid, 1'b0);
        chk("t4_idle_bit",         ws_b.bit_out,   1'b1);
        w = 8'h01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_bit",  ws_b.bit_out,   w[i]);
            chk("t4_done", ws_b.word_done, (i == 7));
        end
        @(negedge clk);
        chk("t4_after_bit",   ws_b.bit_out,   1'b1);
        chk("t4_after_valid", ws_b.bit_valid, 1'b0);

        // Flush mid-word, with a competing push on the flush edge
        #1 dc0 = done_cnt;
        @(negedge clk); ws_a.in_valid = 1'b1; ws_a.in_data = 8'hFF;
        $display("txn: A push 0xff then flush");
        @(negedge clk); ws_a.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_shifting", ws_a.bit_valid, 1'b1);
        ws_a.flush = 1'b1; ws_a.in_valid = 1'b1; ws_a.in_data = 8'h77;
        @(negedge clk); ws_a.flush = 1'b0; ws_a.in_valid = 1'b0;
        chk("t5_bit_out",   ws_a.bit_out,   1'b0);
        chk("t5_bit_valid", ws_a.bit_valid, 1'b0);
        chk("t5_idle",      ws_a.idle,      1'b1);
        chk("t5_word_done", ws_a.word_done, 1'b0);
        repeat (12) @(negedge clk);
        #1 chk("t5_no_done", done_cnt, dc0);

        // Asynchronous reset mid-word, then a clean word
        @(negedge clk); ws_a.in_valid = 1'b1; ws_a.in_data = 8'hF0;
        $display("txn: A push 0xf0 then async reset");
        @(negedge clk); ws_a.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_bit_out",   ws_a.bit_out,   1'b0);
        chk("t6_bit_valid", ws_a.bit_valid, 1'b0);
        chk("t6_word_done", ws_a.word_done, 1'b0);
        chk("t6_idle",      ws_a.idle,      1'b1);
        chk("t6_in_ready",  ws_a.in_ready,  1'b1);
        @(negedge clk); #2 reset = 1'b0;
        #1 stream.delete();
        @(negedge clk); ws_a.in_valid = 1'b1; ws_a.in_data = 8'h81;
        $display("txn: A push 0x81");
        @(negedge clk); ws_a.in_valid = 1'b0;
        @(negedge clk);
        w = 8'h81;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_bit", ws_a.bit_out, w[7-i]);
        end
        repeat (3) @(negedge clk);
        #1 chk("t6_stream_len", stream.size(), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
